ad_bus_reader: RTL and testbench
================================

Name: ad_bus_reader

Overview:
Initiator side of the team's multiplexed 32-bit AD bus; the responder is the existing bufif0 bank that drives {16'b0, regff} onto ad while read is low. This block accepts read requests on a valid/ready interface and drives the address phase. It then releases the bus, asserts read_n, and waits for the responder's ack. It samples the 16-bit read data and returns it with an error flag on a valid/ready response interface.

Parameters:
AD_WIDTH, 32, width of the multiplexed address/data bus.
DATA_WIDTH, 16, width of read data returned by the responder in ad[DATA_WIDTH-1:0].
TURN_CYCLES, 1, bus-release cycles between address phase and read_n assertion (legal range 1..15).
TIMEOUT, 15, WAIT cycles without ack before an error response (legal range 1..255).

Ports:
clk  input  1  sole clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
req_valid  input  1  read request valid.
req_ready  output  1  request accepted when req_valid && req_ready.
req_addr  input  AD_WIDTH  read address.
rsp_valid  output  1  response valid.
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
rsp_data  output  DATA_WIDTH  read data (0 on error).
rsp_err  output  1  1 = timeout or nonzero upper bits.
ad_out  output  AD_WIDTH  value driven onto ad when ad_oe=1.
ad_oe  output  1  tristate enable for ad_out.
ad_in  input  AD_WIDTH  sampled ad bus.
read_n  output  1  active-low read strobe to the responder's bufif0 controls.
ad_ack  input  1  responder data-valid, sampled in WAIT only.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (reset_n).
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, ad_out=0, ad_oe=0, read_n=1, counters=0.
- All outputs are registered. No combinational path from any input to any output.
- IDLE: req_ready=1, ad_oe=0, read_n=1. On req_valid, latch req_addr, set req_ready=0, go to ADDR.
- ADDR (1 cycle): ad_oe=1, ad_out=latched addr, read_n=1. Then go to TURN.
- TURN (TURN_CYCLES cycles): ad_oe=0, ad_out=0, read_n=1. Then go to WAIT with the wait counter cleared.
- WAIT: read_n=0, ad_oe=0.
  - On ad_ack=1: capture ad_in[DATA_WIDTH-1:0] into rsp_data; rsp_err = |ad_in[AD_WIDTH-1:DATA_WIDTH]. Go to RESP.
  - Otherwise, increment the wait counter. When it reaches TIMEOUT, set rsp_data=0, rsp_err=1, go to RESP.
  - ad_ack in the same cycle the counter reaches TIMEOUT: ack wins.
- RESP: rsp_valid=1, read_n=1, ad_oe=0. rsp_data and rsp_err are held stable until rsp_ready=1. Then rsp_valid=0, req_ready=1, go to IDLE.
- Bus-contention rule: ad_oe and !read_n are never both asserted. At least one cycle with ad_oe=0 and read_n=1 separates read_n deassertion from the next ad_oe assertion (the RESP cycle guarantees this).
- Latency with TURN_CYCLES=1 and immediate ack:
  - request accepted at edge 0 → ADDR in cycle 1, TURN in cycle 2, WAIT in cycle 3 (ack sampled), rsp_valid in cycle 4.
  - General latency: 3+TURN_CYCLES cycles plus ack wait.
- Back-to-back: req_ready is 0 from acceptance until the cycle after response handshake. One outstanding read only.
- Requests while busy: req_valid in a non-IDLE state is ignored. The requester must hold the request.
- Reset mid-transaction: immediately returns all outputs to reset values, releases the bus (ad_oe=0, read_n=1) and drops any pending response.
- Counters saturate; wrap-around is never permitted.

Decomposition:
- Package ad_bus_pkg holds:
  - state enum logic [2:0] {IDLE, ADDR, TURN, WAIT, RESP};
  - default width constants AD_WIDTH_DEF=32, DATA_WIDTH_DEF=16;
  - typedef ad_word_t.
- One sub-module, ad_bus_wait_timer: a parameterised load/count/expire counter. It is instanced twice, for the TURN count and for the WAIT timeout.

Test Plan:
1. Basic read: req_addr=32'h0000_1234, ack in the first WAIT cycle with ad_in=32'h0000_BEEF → ad_out=32'h1234 with ad_oe=1 exactly in cycle 1; rsp_valid in cycle 4 with rsp_data=16'hBEEF, rsp_err=0.
2. Wait states: ack after 5 WAIT cycles, ad_in=32'h0000_00A5 → rsp_data=16'h00A5, rsp_err=0. read_n is low for exactly 6 cycles.
3. Timeout: no ack with TIMEOUT=15 → rsp_valid after 15 WAIT cycles with rsp_data=0, rsp_err=1. Also ack in exactly the 15th cycle → no error.
4. Upper-bits check: ack with ad_in=32'h0001_0042 → rsp_data=16'h0042, rsp_err=1.
5. Backpressure and back-to-back: hold rsp_ready=0 for 10 cycles → rsp_data stable, req_ready=0. Release with req_valid held → the next ADDR phase starts in the cycle after IDLE is re-entered. A checker asserts that ad_oe and !read_n are never both high.
6. Reset in WAIT: assert reset_n=0 asynchronously mid-WAIT → read_n=1, ad_oe=0, rsp_valid=0 before the next edge. A fresh read after release completes normally.

Source files
------------

// File: rtl/ad_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ad_bus_pkg
// Description : Shared types and width defaults for the AD bus read initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package ad_bus_pkg;

    localparam int AD_WIDTH_DEF   = 32;
    localparam int DATA_WIDTH_DEF = 16;

    // Bus transaction phases: address drive, bus release, strobe/ack wait, response hold
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        TURN = 3'd2,
        WAIT = 3'd3,
        RESP = 3'd4
    } state_t;

    typedef logic [AD_WIDTH_DEF-1:0] ad_word_t;

endpackage : ad_bus_pkg
`default_nettype wire

// File: rtl/ad_bus_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : ad_bus_wait_timer
// Description : Clear/count/expire counter. o_last is high while the count
//               sits at LIMIT-1, i.e. during the final cycle of the interval.
//               The count saturates there and never wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module ad_bus_wait_timer
    import ad_bus_pkg::*;
#(
    parameter int LIMIT = 15,
    parameter int WIDTH = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_last
);

    localparam logic [WIDTH-1:0] c_LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] r_count;

    // Count enabled cycles; clear has priority, and the count holds at the last value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != c_LAST)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_last = (r_count == c_LAST);

endmodule : ad_bus_wait_timer
`default_nettype wire

// File: rtl/ad_bus_reader.sv
`default_nettype none
// ============================================================================
// Module      : ad_bus_reader
// Description : Read initiator for the multiplexed AD bus. Drives one address
//               cycle, releases the bus for TURN_CYCLES, strobes read_n low
//               until ack or timeout, then presents data on a valid/ready
//               response port. All outputs come straight from flops.
// Revision    : 1.0 - initial release
// ============================================================================
module ad_bus_reader
    import ad_bus_pkg::*;
#(
    parameter int AD_WIDTH    = AD_WIDTH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int TURN_CYCLES = 1,
    parameter int TIMEOUT     = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [AD_WIDTH-1:0]   req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic [AD_WIDTH-1:0]   ad_out,
    output logic                  ad_oe,
    input  logic [AD_WIDTH-1:0]   ad_in,
    output logic                  read_n,
    input  logic                  ad_ack
);

    state_t                r_state;
    state_t                w_next_state;

    logic                  w_turn_clear;
    logic                  w_turn_en;
    logic                  w_turn_last;
    logic                  w_wait_clear;
    logic                  w_wait_en;
    logic                  w_wait_last;

    logic                  w_capture;
    logic [DATA_WIDTH-1:0] w_cap_data;
    logic                  w_cap_err;

    // Counts the bus-release cycles between address phase and read strobe
    ad_bus_wait_timer #(
        .LIMIT   (TURN_CYCLES)
    ) u_turn_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (w_turn_clear),
        .i_en    (w_turn_en),
        .o_last  (w_turn_last)
    );

    // Counts WAIT cycles without ack; o_last marks the cycle that times out
    ad_bus_wait_timer #(
        .LIMIT   (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (w_wait_clear),
        .i_en    (w_wait_en),
        .o_last  (w_wait_last)
    );

    // Next-state decode, timer control and response capture values
    always_comb begin
        w_next_state = r_state;
        w_turn_clear = 1'b0;
        w_turn_en    = 1'b0;
        w_wait_clear = 1'b0;
        w_wait_en    = 1'b0;
        w_capture    = 1'b0;
        w_cap_data   = '0;
        w_cap_err    = 1'b0;

        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_next_state = ADDR;
                end
            end
            ADDR: begin
                w_turn_clear = 1'b1;
                w_next_state = TURN;
            end
            TURN: begin
                // WAIT must start from a zero count
                w_wait_clear = 1'b1;
                if (w_turn_last) begin
                    w_next_state = WAIT;
                end else begin
                    w_turn_en = 1'b1;
                end
            end
            WAIT: begin
                if (ad_ack) begin
                    // Ack takes priority over a simultaneous timeout
                    w_next_state = RESP;
                    w_capture    = 1'b1;
                    w_cap_data   = ad_in[DATA_WIDTH-1:0];
                    w_cap_err    = |ad_in[AD_WIDTH-1:DATA_WIDTH];
                end else if (w_wait_last) begin
                    w_next_state = RESP;
                    w_capture    = 1'b1;
                    w_cap_data   = '0;
                    w_cap_err    = 1'b1;
                end else begin
                    w_wait_en = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register; every output is decoded from the next state so it is
    // registered and aligned with the phase it belongs to
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            ad_out    <= '0;
            ad_oe     <= 1'b0;
            read_n    <= 1'b1;
        end else begin
            r_state   <= w_next_state;
            req_ready <= (w_next_state == IDLE);
            rsp_valid <= (w_next_state == RESP);
            ad_oe     <= (w_next_state == ADDR);
            read_n    <= (w_next_state != WAIT);
            // ADDR is only reachable from IDLE, so this latches the accepted address
            ad_out    <= (w_next_state == ADDR) ? req_addr : '0;
            if (w_capture) begin
                rsp_data <= w_cap_data;
                rsp_err  <= w_cap_err;
            end
        end
    end

endmodule : ad_bus_reader
`default_nettype wire

// File: tb/tb_ad_bus_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ad_bus_reader
// Description : Directed self-checking bench for ad_bus_reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ad_bus_reader;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [31:0] ad_out;
    logic        ad_oe;
    logic [31:0] ad_in;
    logic        read_n;
    logic        ad_ack;

    int n_compared   = 0;
    int n_mismatched = 0;

    ad_bus_reader #(
        .AD_WIDTH    (32),
        .DATA_WIDTH  (16),
        .TURN_CYCLES (1),
        .TIMEOUT     (15)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .ad_out    (ad_out),
        .ad_oe     (ad_oe),
        .ad_in     (ad_in),
        .read_n    (read_n),
        .ad_ack    (ad_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bus contention watch on the falling edge
    always @(negedge clk) begin
        if (reset_n) check_eq("bus_contention", {31'b0, ad_oe & ~read_n}, 32'd0);
    end

    // Accept a request, check ADDR and TURN, and leave the bench in WAIT cycle 1
    task automatic issue(input string tag, input logic [31:0] addr);
        check_eq({tag, ":idle_req_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        step();
        req_valid = 1'b0;
        check_eq({tag, ":addr_oe"},    {31'b0, ad_oe},     32'd1);
        check_eq({tag, ":addr_out"},   ad_out,             addr);
        check_eq({tag, ":addr_readn"}, {31'b0, read_n},    32'd1);
        check_eq({tag, ":addr_ready"}, {31'b0, req_ready}, 32'd0);
        step();
        check_eq({tag, ":turn_oe"},    {31'b0, ad_oe},  32'd0);
        check_eq({tag, ":turn_out"},   ad_out,          32'd0);
        check_eq({tag, ":turn_readn"}, {31'b0, read_n}, 32'd1);
        step();
    endtask

    // Run WAIT with ack in WAIT cycle ack_at (0 = never), check response,
    // optionally hold rsp_ready low, then handshake. With nxt_valid the next
    // request is already presented during the handshake.
    task automatic finish(input string tag, input int ack_at, input logic [31:0] din,
                          input logic [15:0] exp_d, input logic exp_e, input int exp_low,
                          input int hold, input logic nxt_valid, input logic [31:0] nxt_addr);
        int low;
        int n;
        low = 0;
        n   = 0;
        ad_in = din;
        while (!rsp_valid && n < 40) begin
            if (!read_n) low++;
            n++;
            ad_ack = (n == ack_at);
            step();
            ad_ack = 1'b0;
        end
        check_eq({tag, ":readn_low_cycles"}, low, exp_low);
        check_eq({tag, ":rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
        check_eq({tag, ":rsp_data"},  {16'b0, rsp_data},  {16'b0, exp_d});
        check_eq({tag, ":rsp_err"},   {31'b0, rsp_err},   {31'b0, exp_e});
        check_eq({tag, ":resp_readn"}, {31'b0, read_n},   32'd1);
        ad_in = 32'hFFFF_FFFF;
        for (int i = 0; i < hold; i++) begin
            step();
            check_eq({tag, ":hold_valid"}, {31'b0, rsp_valid}, 32'd1);
            check_eq({tag, ":hold_data"},  {16'b0, rsp_data},  {16'b0, exp_d});
            check_eq({tag, ":hold_err"},   {31'b0, rsp_err},   {31'b0, exp_e});
            check_eq({tag, ":hold_ready"}, {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        if (nxt_valid) begin
            req_valid = 1'b1;
            req_addr  = nxt_addr;
        end
        step();
        rsp_ready = 1'b0;
        check_eq({tag, ":post_valid"}, {31'b0, rsp_valid}, 32'd0);
        check_eq({tag, ":post_ready"}, {31'b0, req_ready}, 32'd1);
        check_eq({tag, ":post_oe"},    {31'b0, ad_oe},     32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_addr  = 32'd0;
        rsp_ready = 1'b0;
        ad_in     = 32'd0;
        ad_ack    = 1'b0;
        step();
        step();
        check_eq("reset:req_ready", {31'b0, req_ready}, 32'd1);
        check_eq("reset:rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check_eq("reset:rsp_data",  {16'b0, rsp_data},  32'd0);
        check_eq("reset:rsp_err",   {31'b0, rsp_err},   32'd0);
        check_eq("reset:ad_out",    ad_out,             32'd0);
        check_eq("reset:ad_oe",     {31'b0, ad_oe},     32'd0);
        check_eq("reset:read_n",    {31'b0, read_n},    32'd1);
        reset_n = 1'b1;
        step();

        // Basic read, immediate ack
        issue("basic", 32'h0000_1234);
        finish("basic", 1, 32'h0000_BEEF, 16'hBEEF, 1'b0, 1, 0, 1'b0, 32'd0);

        // Ack in the sixth WAIT cycle
        issue("wait5", 32'h0000_0010);
        finish("wait5", 6, 32'h0000_00A5, 16'h00A5, 1'b0, 6, 0, 1'b0, 32'd0);

        // No ack: timeout after 15 WAIT cycles, data forced to zero
        issue("timeout", 32'h0000_0020);
        finish("timeout", 0, 32'h0000_7777, 16'h0000, 1'b1, 15, 0, 1'b0, 32'd0);

        // Ack in the 15th WAIT cycle wins over the timeout
        issue("ack15", 32'h0000_0030);
        finish("ack15", 15, 32'h0000_3C3C, 16'h3C3C, 1'b0, 15, 0, 1'b0, 32'd0);

        // Nonzero upper bits flag an error but still return the low half
        issue("upper", 32'h0000_0040);
        finish("upper", 1, 32'h0001_0042, 16'h0042, 1'b1, 1, 0, 1'b0, 32'd0);

        // Backpressure for 10 cycles, next request held through the handshake
        issue("bp", 32'hA5A5_0001);
        finish("bp", 2, 32'h0000_1357, 16'h1357, 1'b0, 2, 10, 1'b1, 32'h5A5A_0002);
        issue("b2b", 32'h5A5A_0002);
        finish("b2b", 1, 32'h0000_2468, 16'h2468, 1'b0, 1, 0, 1'b0, 32'd0);

        // Asynchronous reset in the middle of WAIT
        issue("rst", 32'h0000_0050);
        check_eq("rst:wait_readn", {31'b0, read_n}, 32'd0);
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rst:async_readn",  {31'b0, read_n},    32'd1);
        check_eq("rst:async_oe",     {31'b0, ad_oe},     32'd0);
        check_eq("rst:async_valid",  {31'b0, rsp_valid}, 32'd0);
        check_eq("rst:async_ready",  {31'b0, req_ready}, 32'd1);
        step();
        reset_n = 1'b1;
        step();
        issue("fresh", 32'h0000_0060);
        finish("fresh", 3, 32'h0000_0F0F, 16'h0F0F, 1'b0, 3, 0, 1'b0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_ad_bus_reader
`default_nettype wire
